// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction fetch front end: opcode constants,
// fetch FSM encoding, queue entry layout and RISC-V J/B immediate extractors
// (the decoder uses the same extractors).
package instruction_fetcher_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // IDLE : nothing outstanding, waiting for queue room
    // REQ  : request outstanding, address held for the whole miss
    // GAP  : one dead cycle after a response; a duplicate strobe is dropped here
    // DRAIN: request was outstanding when a redirect arrived; its response is dropped
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // One buffered instruction as handed to the decoder.
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        pred;
    } fq_entry_t;

    // Sign-extended JAL offset.
    function automatic logic [31:0] j_imm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    // Sign-extended conditional branch offset.
    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bus bundle between the fetcher, the instruction cache, the decoder and the
// backend redirect path. The fetcher uses the master modport; the
// environment (cache, decoder, backend) uses the slave modport.
//
// Handshake semantics:
//   cache  : ic_ins_asked is a level request with ic_ins_addr held stable
//            until the one-cycle ic_ins_rdy strobe; ic_ins is valid only
//            while ic_ins_rdy is high.
//   decoder: strict valid/ready. dec_ins_valid does not depend on
//            dec_ins_ready; an entry transfers on every edge where both are
//            high (and the global enable is high).
//   backend: br_flush is a one-cycle redirect with br_target valid alongside.
interface instruction_fetcher_if;

    logic        ic_ins_asked;
    logic [31:0] ic_ins_addr;
    logic        ic_ins_rdy;
    logic [31:0] ic_ins;

    logic        dec_ins_valid;
    logic [31:0] dec_ins;
    logic [31:0] dec_ins_pc;
    logic        dec_pred_taken;
    logic        dec_ins_ready;

    logic        br_flush;
    logic [31:0] br_target;

    modport master (
        output ic_ins_asked,
        output ic_ins_addr,
        input  ic_ins_rdy,
        input  ic_ins,
        output dec_ins_valid,
        output dec_ins,
        output dec_ins_pc,
        output dec_pred_taken,
        input  dec_ins_ready,
        input  br_flush,
        input  br_target
    );

    modport slave (
        input  ic_ins_asked,
        input  ic_ins_addr,
        output ic_ins_rdy,
        output ic_ins,
        input  dec_ins_valid,
        input  dec_ins,
        input  dec_ins_pc,
        input  dec_pred_taken,
        output dec_ins_ready,
        output br_flush,
        output br_target
    );

endinterface

// File: rtl/instruction_fetcher_fetch_queue.sv
// Small FIFO of fetched instructions. Head/tail pointers wrap naturally
// because DEPTH is a power of two; count is one bit wider than the pointers
// so that full and empty are distinct. Flush empties the queue and wins over
// push and pop in the same cycle. Everything holds while en is low.
module fetch_queue
    import instruction_fetcher_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    output fq_entry_t     head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          do_push;
    logic          do_pop;

    // Effective push/pop after enable, flush priority and empty protection.
    always_comb begin
        do_push = en && !flush && push;
        do_pop  = en && !flush && pop && (count != '0);
    end

    // Entry storage; cleared at reset so the head outputs start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[tail_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (en) begin
            if (flush) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (do_push) begin
                    tail_ptr <= tail_ptr + PW'(1);
                end
                if (do_pop) begin
                    head_ptr <= head_ptr + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Head is read straight out of the storage registers.
    always_comb begin
        head       = mem[head_ptr];
        head_valid = (count != '0);
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: owns the PC, keeps at most one request outstanding to
// the instruction cache, statically predicts JAL and backward branches as
// taken, and buffers fetched words for the decoder. Backend redirects empty
// the queue and steer the PC; a response still in flight at redirect time is
// waited out and dropped.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter  int          FQ_DEPTH = 4,
    parameter  logic [31:0] RESET_PC = 32'h0,
    localparam int          CW       = $clog2(FQ_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    instruction_fetcher_if.master   bus,
    output fetch_state_t            dbg_state,
    output logic [CW-1:0]           dbg_count
);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   next_pc;
    logic          pred_taken;
    logic          q_push;
    logic          q_pop;
    logic          q_room_now;
    logic          q_room_after_pop;
    fq_entry_t     q_push_data;
    fq_entry_t     q_head;
    logic          q_head_valid;
    logic [CW-1:0] q_count;

    // Static prediction on the word arriving from the cache.
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc + 32'd4;
        if (bus.ic_ins[6:0] == OPC_JAL) begin
            pred_taken = 1'b1;
            next_pc    = pc + j_imm(bus.ic_ins);
        end else if ((bus.ic_ins[6:0] == OPC_BRANCH) && bus.ic_ins[31]) begin
            pred_taken = 1'b1;
            next_pc    = pc + b_imm(bus.ic_ins);
        end
    end

    // Queue control: capture only a live response in REQ; a redirect in the
    // same cycle drops it (the queue also ignores push while flushing).
    always_comb begin
        q_push           = (state == ST_REQ) && bus.ic_ins_rdy && !bus.br_flush;
        q_push_data      = '{ins: bus.ic_ins, pc: pc, pred: pred_taken};
        q_pop            = q_head_valid && bus.dec_ins_ready;
        q_room_now       = (q_count < CW'(FQ_DEPTH));
        // GAP never pushes, so room after this cycle is room now or a pop.
        q_room_after_pop = q_room_now || q_pop;
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (rdy),
        .flush      (bus.br_flush),
        .push       (q_push),
        .push_data  (q_push_data),
        .pop        (q_pop),
        .head       (q_head),
        .head_valid (q_head_valid),
        .count      (q_count)
    );

    // Fetch FSM with registered cache request outputs and PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pc               <= RESET_PC;
            bus.ic_ins_asked <= 1'b0;
            bus.ic_ins_addr  <= RESET_PC;
        end else if (rdy) begin
            if (bus.br_flush) begin
                pc               <= bus.br_target;
                bus.ic_ins_asked <= 1'b0;
                case (state)
                    // Still waiting on the cache: its answer must be dropped.
                    ST_REQ:   state <= bus.ic_ins_rdy ? ST_GAP : ST_DRAIN;
                    // A stale answer arriving with a second redirect is
                    // consumed here too, otherwise DRAIN would never exit.
                    ST_DRAIN: state <= bus.ic_ins_rdy ? ST_GAP : ST_DRAIN;
                    default:  state <= ST_GAP;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (q_room_now) begin
                            state            <= ST_REQ;
                            bus.ic_ins_asked <= 1'b1;
                            bus.ic_ins_addr  <= pc;
                        end
                    end
                    ST_REQ: begin
                        if (bus.ic_ins_rdy) begin
                            pc               <= next_pc;
                            bus.ic_ins_asked <= 1'b0;
                            state            <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        // Any strobe seen now is the cache's duplicate hit.
                        if (q_room_after_pop) begin
                            state            <= ST_REQ;
                            bus.ic_ins_asked <= 1'b1;
                            bus.ic_ins_addr  <= pc;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.ic_ins_rdy) begin
                            state <= ST_GAP;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Decoder-facing outputs come from the queue head registers.
    always_comb begin
        bus.dec_ins_valid  = q_head_valid;
        bus.dec_ins        = q_head.ins;
        bus.dec_ins_pc     = q_head.pc;
        bus.dec_pred_taken = q_head.pred;
        dbg_state          = state;
        dbg_count          = q_count;
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a behavioural cache, a
// reference PC/prediction model feeding an expected-entry queue, and a
// decoder-side scoreboard.
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    localparam int FQ_DEPTH = 4;
    localparam int CW       = $clog2(FQ_DEPTH) + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rdy;
    fetch_state_t dbg_state;
    logic [CW-1:0] dbg_count;

    instruction_fetcher_if bus ();

    instruction_fetcher #(
        .FQ_DEPTH (FQ_DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [64:0] exp_q[$];

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- environment knobs (written by main only) ----------------
    bit fwd_mode   = 1'b0;
    bit dup_en     = 1'b0;
    bit chk_period = 1'b0;
    int miss_lat   = 1;

    // ---------------- program image ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0080006F;                             // jal x0, +8
            32'h20:  return fwd_mode ? 32'h00000863 : 32'hFE0008E3;   // beq +16 / beq -16
            default: return 32'h00000013;                             // nop
        endcase
    endfunction

    // Reference prediction: returns {pred, next_pc}.
    function automatic logic [32:0] ref_predict(input logic [31:0] pc, input logic [31:0] ins);
        logic [20:0] joff;
        logic [12:0] boff;
        joff = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        boff = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (ins[6:0] == 7'h6F)
            return {1'b1, pc + {{11{joff[20]}}, joff}};
        if (ins[6:0] == 7'h63 && boff[12])
            return {1'b1, pc + {{19{boff[12]}}, boff}};
        return {1'b0, pc + 32'd4};
    endfunction

    // ---------------- environment: cache + decoder scoreboard ----------------
    bit          cache_busy  = 1'b0;
    bit          cache_stale = 1'b0;
    bit          dup_pending = 1'b0;
    int          cache_cnt   = 0;
    logic [31:0] cache_addr  = 32'h0;
    logic [31:0] exp_pc      = 32'h0;
    int          req_starts  = 0;
    int          last_start  = -1;
    int          strobe_cycle = 0;

    initial begin
        logic [32:0] pn;
        logic [31:0] w;
        bus.ic_ins_rdy = 1'b0;
        bus.ic_ins     = 32'h0;
        forever begin
            @(negedge clk);
            bus.ic_ins_rdy = 1'b0;
            if (!rst_n) begin
                cache_busy  = 1'b0;
                cache_stale = 1'b0;
                dup_pending = 1'b0;
                exp_pc      = 32'h0;
                exp_q.delete();
            end else begin
                if (dup_pending) begin
                    bus.ic_ins_rdy = 1'b1;
                    bus.ic_ins     = 32'h00100093;
                    dup_pending    = 1'b0;
                end else if (cache_busy) begin
                    cache_cnt++;
                    check("req_addr_held", bus.ic_ins_addr, cache_addr);
                    if (cache_cnt >= miss_lat) begin
                        w              = mem_word(cache_addr);
                        bus.ic_ins_rdy = 1'b1;
                        bus.ic_ins     = w;
                        cache_busy     = 1'b0;
                        strobe_cycle   = cycle;
                        if (!cache_stale) begin
                            pn = ref_predict(cache_addr, w);
                            exp_q.push_back({w, cache_addr, pn[32]});
                            exp_pc = pn[31:0];
                        end
                        cache_stale = 1'b0;
                        dup_pending = dup_en;
                    end
                end else if (bus.ic_ins_asked) begin
                    cache_busy = 1'b1;
                    cache_addr = bus.ic_ins_addr;
                    cache_cnt  = 0;
                    check("req_addr", bus.ic_ins_addr, exp_pc);
                    if (chk_period && last_start >= 0)
                        check("hit_period", cycle - last_start, 3);
                    last_start = cycle;
                    req_starts++;
                end
            end
            // Decoder side, after main has driven this cycle's inputs.
            #3;
            if (rst_n && rdy && !bus.br_flush && bus.dec_ins_valid && bus.dec_ins_ready) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("dec_entry", {bus.dec_ins, bus.dec_ins_pc, bus.dec_pred_taken}, exp_q.pop_front());
            end
            if (rst_n && rdy && bus.br_flush) begin
                exp_q.delete();
                if (cache_busy) cache_stale = 1'b1;
                exp_pc = bus.br_target;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_flush(input logic [31:0] t);
        bus.br_flush  = 1'b1;
        bus.br_target = t;
        step();
        bus.br_flush  = 1'b0;
    endtask

    task automatic wait_req(output logic [31:0] a);
        int s;
        s = req_starts;
        for (int i = 0; i < 100 && req_starts == s; i++) step();
        check("req_timeout", req_starts != s, 1);
        a = cache_addr;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] a;
        int          s;
        logic        asked_seen;

        rst_n             = 1'b0;
        rdy               = 1'b1;
        bus.dec_ins_ready = 1'b0;
        bus.br_flush      = 1'b0;
        bus.br_target     = 32'h0;
        repeat (3) step();

        // Reset values
        check("rst_asked", bus.ic_ins_asked, 0);
        check("rst_addr", bus.ic_ins_addr, 32'h0);
        check("rst_valid", bus.dec_ins_valid, 0);
        check("rst_dec_ins", bus.dec_ins, 0);
        check("rst_dec_pc", bus.dec_ins_pc, 0);
        check("rst_pred", bus.dec_pred_taken, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_count", dbg_count, 0);

        // Sequential nops, JAL at 0x10, backward BEQ at 0x20
        chk_period        = 1'b1;
        bus.dec_ins_ready = 1'b1;
        rst_n             = 1'b1;
        a = 32'h0;
        for (int i = 0; i < 12; i++) begin
            wait_req(a);
            if (a == 32'h20) break;
        end
        check("reach_0x20", a, 32'h20);
        wait_req(a);
        check("beq_back_target", a, 32'h10);
        wait_req(a);
        check("jal_target", a, 32'h18);
        chk_period = 1'b0;

        // Forward BEQ at 0x20 falls through
        fwd_mode = 1'b1;
        do_flush(32'h20);
        wait_req(a);
        check("fwd_req", a, 32'h20);
        wait_req(a);
        check("fwd_fallthrough", a, 32'h24);

        // Queue fill with decoder stalled
        bus.dec_ins_ready = 1'b0;
        do_flush(32'h40);
        repeat (30) step();
        check("full_count", dbg_count, FQ_DEPTH);
        check("full_valid", bus.dec_ins_valid, 1);
        check("full_state", dbg_state, ST_IDLE);
        asked_seen = 1'b0;
        repeat (6) begin
            step();
            asked_seen = asked_seen | bus.ic_ins_asked;
        end
        check("full_no_req", asked_seen, 0);

        // Global enable low: nothing moves even with decoder ready
        rdy               = 1'b0;
        bus.dec_ins_ready = 1'b1;
        repeat (3) step();
        check("hold_count", dbg_count, FQ_DEPTH);
        check("hold_state", dbg_state, ST_IDLE);
        check("hold_asked", bus.ic_ins_asked, 0);

        // One pop gives exactly one refill request
        rdy = 1'b1;
        s   = req_starts;
        step();
        bus.dec_ins_ready = 1'b0;
        repeat (12) step();
        check("one_pop_one_req", req_starts - s, 1);
        check("refill_count", dbg_count, FQ_DEPTH);

        // Redirect during a long miss
        bus.dec_ins_ready = 1'b1;
        step();
        miss_lat = 10;
        do_flush(32'h40);
        wait_req(a);
        check("miss_req", a, 32'h40);
        repeat (3) step();
        do_flush(32'h100);
        for (int i = 0; i < 30; i++) begin
            if (!cache_busy) break;
            check("drain_state", dbg_state, ST_DRAIN);
            check("drain_asked", bus.ic_ins_asked, 0);
            check("drain_empty", bus.dec_ins_valid, 0);
            step();
        end
        check("drain_strobe_seen", cache_busy, 0);
        miss_lat = 1;
        wait_req(a);
        check("redirect_req", a, 32'h100);
        check("strobe_to_req", last_start - strobe_cycle, 2);

        // Duplicate strobe in the GAP cycle is ignored
        dup_en            = 1'b1;
        bus.dec_ins_ready = 1'b0;
        do_flush(32'h200);
        for (int i = 0; i < 20 && !bus.dec_ins_valid; i++) step();
        check("dup_first_valid", bus.dec_ins_valid, 1);
        repeat (2) step();
        check("dup_count1", dbg_count, 1);
        repeat (20) step();
        check("dup_count_full", dbg_count, FQ_DEPTH);
        dup_en            = 1'b0;
        bus.dec_ins_ready = 1'b1;
        repeat (20) step();

        // Asynchronous reset takes effect without a clock edge
        rst_n = 1'b0;
        #1;
        check("async_rst_asked", bus.ic_ins_asked, 0);
        check("async_rst_state", dbg_state, ST_IDLE);
        check("async_rst_count", dbg_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Upstream neighbour of the instruction cache. Owns the program counter and issues one single-outstanding fetch request at a time to the cache. Statically predicts control flow (JAL taken, backward conditional branches taken) and buffers fetched instructions in a small queue for the decoder. Handles backend redirects, including discarding a response still in flight.

## Interface
- FQ_DEPTH, 4: instruction queue entries (power of two, ≥2)
- RESET_PC, 32'h0: PC after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low all state holds
- ic_ins_asked  out  1  fetch request to cache
- ic_ins_addr  out  32  fetch address
- ic_ins_rdy  in  1  one-cycle response strobe from cache
- ic_ins  in  32  fetched instruction, valid with ic_ins_rdy
- dec_ins_valid  out  1  queue head valid
- dec_ins  out  32  head instruction
- dec_ins_pc  out  32  head PC
- dec_pred_taken  out  1  head predicted taken
- dec_ins_ready  in  1  decoder accepts head this cycle
- br_flush  in  1  backend redirect (mispredict/JALR)
- br_target  in  32  redirect PC

## Operation
- States: IDLE, REQ, GAP, DRAIN.
- IDLE: if queue count < FQ_DEPTH → REQ; ic_ins_asked<=1, ic_ins_addr<=pc.
- REQ: hold ic_ins_asked=1 and ic_ins_addr stable (cache re-reads the address throughout a miss). On ic_ins_rdy: push {ic_ins, pc, pred} into queue, pc<=next_pc, ic_ins_asked<=0 → GAP.
- GAP: one cycle, ic_ins_asked=0; any ic_ins_rdy seen here is the cache's duplicate hit and is discarded. Then → REQ if count < FQ_DEPTH (after this cycle's pop), else IDLE.
- DRAIN: request outstanding at flush time. Keep ic_ins_asked=0 but ic_ins_addr unchanged. On ic_ins_rdy, discard the response → GAP.
- Prediction on captured word (opcode = ins[6:0]):
  - JAL (7'b1101111): next_pc = pc + sext(J-imm), pred=1.
  - BRANCH (7'b1100011) with B-imm sign bit 1: next_pc = pc + sext(B-imm), pred=1.
  - Otherwise (incl. JALR): next_pc = pc+4, pred=0.
  - All adds mod 2^32.
- Queue: FIFO with head/tail pointers wrapping mod FQ_DEPTH, plus count (width clog2(FQ_DEPTH)+1).
  - Pop when dec_ins_valid && dec_ins_ready; dec_ins_valid = (count != 0).
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs when full: a request issues only with count < FQ_DEPTH, and only one is outstanding.
- br_flush (priority over everything except reset):
  - Queue emptied; pc<=br_target; same-cycle ic_ins_rdy discarded.
  - From REQ with response not yet received → DRAIN.
  - From REQ with ic_ins_rdy this cycle, from GAP, or from IDLE → GAP (cache duplicate possible), then request br_target.
  - In DRAIN: pc updated, stay in DRAIN.
- rdy low: no state change, no push/pop, outputs hold.

## Timing
- Reset values: ic_ins_asked 0, ic_ins_addr RESET_PC, pc RESET_PC, state IDLE, count 0, dec_ins_valid 0, dec_ins 0, dec_ins_pc 0, dec_pred_taken 0.
- Cache hit: request at edge 0, cache strobe after edge 1, capture at edge 2, dec_ins_valid high after edge 2. Next request at edge 3, so steady-state hit throughput is 1 instruction per 3 cycles.
- Miss: capture on the edge following the ic_ins_rdy cycle, regardless of miss length.
- Flush-to-new-request: ≥2 edges (GAP); from DRAIN, the wait for the stale response plus GAP.
- dec_* outputs driven from queue head registers; no combinational path from ic_ins.

## Structure
- Shared package: opcode constants (OPC_JAL, OPC_BRANCH), fetch-state encoding, J/B immediate-extract functions (shared with decoder).
- Sub-module fetch_queue (parameterised FIFO: push/pop/flush, count, head outputs); prediction and FSM stay in instruction_fetcher.

## Test plan
- Reset with RESET_PC=0, cache returns 32'h00000013 at every address on hit → queue receives PCs 0,4,8,12 in order, one per 3 cycles; dec_pred_taken=0.
- PC 0x10 holds JAL +8 (32'h0080006F) → next request address 0x18, entry pred=1.
- Backward BEQ at 0x20 offset −16 → next address 0x10; forward BEQ offset +16 → next address 0x24.
- dec_ins_ready=0 with FQ_DEPTH=4 → exactly 4 entries, ic_ins_asked stays 0; one pop → one new request.
- br_flush to 0x100 during a 10-cycle miss at 0x40 → ic_ins_addr held at 0x40 until strobe, response discarded, GAP, then request 0x100; queue empty throughout.
- Duplicate ic_ins_rdy in GAP cycle → not enqueued; count increments by exactly 1 per fetch.
